// File: rtl/fixed_div.sv
// Sequential unsigned fixed-point divider: out = (in1 << FRACTIONAL_BITS) / in2.
// Restoring division, one quotient bit per clock, valid/ready on both sides.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (in1 dividend, in2 divisor)
//   out_valid/out_ready result handshake
//   out               low TOTAL_BITS of the quotient, same Q format
//   overflow          quotient did not fit in TOTAL_BITS (out has wrapped)
//   div_by_zero       divisor was zero (out forced to all ones)
module fixed_div #(
    parameter int TOTAL_BITS      = 7,
    parameter int FRACTIONAL_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TOTAL_BITS-1:0] in1,
    input  logic [TOTAL_BITS-1:0] in2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TOTAL_BITS-1:0] out,
    output logic                  overflow,
    output logic                  div_by_zero
);

    localparam int ITER = TOTAL_BITS + FRACTIONAL_BITS;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] ITER_C = CW'(ITER);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       count;
    logic [ITER-1:0]     dvd;
    logic [ITER-1:0]     quo;
    logic [TOTAL_BITS-1:0] dvs;
    logic [TOTAL_BITS:0] rem;

    logic [TOTAL_BITS:0] rsh;
    logic [TOTAL_BITS:0] rnext;
    logic                ge;
    logic [ITER-1:0]     qnext;
    logic                ovf;

    // The remainder is always below the divisor, so its top bit stays
    // zero and the quotient MSB is only ever shifted out.
    logic unused_bits;
    assign unused_bits = rem[TOTAL_BITS] ^ quo[ITER-1];

    always_comb begin
        rsh   = {rem[TOTAL_BITS-1:0], dvd[ITER-1]};
        ge    = (rsh >= {1'b0, dvs});
        rnext = ge ? (rsh - {1'b0, dvs}) : rsh;
        qnext = {quo[ITER-2:0], ge};
        ovf   = 1'b0;
        for (int i = TOTAL_BITS; i < ITER; i++) begin
            ovf = ovf | qnext[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            count       <= '0;
            dvd         <= '0;
            quo         <= '0;
            dvs         <= '0;
            rem         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd      <= ITER'(in1) << FRACTIONAL_BITS;
                        dvs      <= in2;
                        rem      <= '0;
                        quo      <= '0;
                        in_ready <= 1'b0;
                        overflow <= 1'b0;
                        if (in2 == '0) begin
                            out         <= '1;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            count       <= ITER_C;
                            div_by_zero <= 1'b0;
                            state       <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem   <= rnext;
                    quo   <= qnext;
                    dvd   <= dvd << 1;
                    count <= count - ONE_C;
                    if (count == ONE_C) begin
                        out       <= qnext[TOTAL_BITS-1:0];
                        overflow  <= ovf;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_div.sv
// Directed testbench for fixed_div with default parameters (Q4.3, ITER=10).
// Each task drives one scenario and checks its own expectations inline.
module tb_fixed_div;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in1;
    logic [6:0] in2;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out;
    logic       overflow;
    logic       div_by_zero;

    int checks;
    int fails;

    fixed_div #(
        .TOTAL_BITS(7),
        .FRACTIONAL_BITS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in1(in1),
        .in2(in2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out(out),
        .overflow(overflow),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for exactly one accepting edge; returns #1 after it.
    task automatic issue(input logic [6:0] a, input logic [6:0] b);
        @(negedge clk);
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until out_valid; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out !== 7'h00) begin
            fails++;
            $display("FAIL reset_out got %h want 00", out);
        end
        checks++;
        if (overflow !== 1'b0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got ovf=%b dz=%b want 0 0",
                     overflow, div_by_zero);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        issue(7'h18, 7'h10);
        wait_valid(lat);
        checks++;
        if (lat !== 10) begin
            fails++;
            $display("FAIL basic_latency got %0d want 10", lat);
        end
        checks++;
        if (out !== 7'h0C || overflow !== 1'b0 || div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL basic_result got out=%h ovf=%b dz=%b want 0c 0 0",
                     out, overflow, div_by_zero);
        end
        ack();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_release got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_large();
        int lat;
        issue(7'h3C, 7'h04);
        wait_valid(lat);
        checks++;
        if (lat !== 10 || out !== 7'h78 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL large_exact got lat=%0d out=%h ovf=%b want 10 78 0",
                     lat, out, overflow);
        end
        ack();
        issue(7'h78, 7'h04);
        wait_valid(lat);
        checks++;
        if (lat !== 10 || out !== 7'h70 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL large_wrap got lat=%0d out=%h ovf=%b want 10 70 1",
                     lat, out, overflow);
        end
        checks++;
        if (div_by_zero !== 1'b0) begin
            fails++;
            $display("FAIL large_dz got %b want 0", div_by_zero);
        end
        ack();
    endtask

    task automatic test_trunc();
        int lat;
        issue(7'h08, 7'h18);
        wait_valid(lat);
        checks++;
        if (lat !== 10 || out !== 7'h02 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL trunc_third got lat=%0d out=%h ovf=%b want 10 02 0",
                     lat, out, overflow);
        end
        ack();
        issue(7'h00, 7'h08);
        wait_valid(lat);
        checks++;
        if (lat !== 10 || out !== 7'h00 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL trunc_zero got lat=%0d out=%h ovf=%b want 10 00 0",
                     lat, out, overflow);
        end
        ack();
    endtask

    task automatic test_div_zero();
        int lat;
        issue(7'h18, 7'h00);
        wait_valid(lat);
        checks++;
        if (lat !== 0) begin
            fails++;
            $display("FAIL dz_latency got %0d want 0 extra edges", lat);
        end
        checks++;
        if (out !== 7'h7F || div_by_zero !== 1'b1 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL dz_result got out=%h dz=%b ovf=%b want 7f 1 0",
                     out, div_by_zero, overflow);
        end
        ack();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL dz_release got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(7'h3C, 7'h04);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 7'h78 ||
                overflow !== 1'b0 || div_by_zero !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d got vld=%b rdy=%b out=%h ovf=%b dz=%b want 1 0 78 0 0",
                         i, out_valid, in_ready, out, overflow, div_by_zero);
            end
        end
        ack();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_busy_ignored();
        int lat;
        issue(7'h08, 7'h18);
        in1      = 7'h78;
        in2      = 7'h04;
        in_valid = 1'b1;
        wait_valid(lat);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (lat !== 10 || out !== 7'h02 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL busy_ignore got lat=%0d out=%h ovf=%b want 10 02 0",
                     lat, out, overflow);
        end
        ack();
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL busy_no_extra got rdy=%b vld=%b want 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(7'h78, 7'h04);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 7'h00) begin
            fails++;
            $display("FAIL midreset_async got rdy=%b vld=%b out=%h want 1 0 00",
                     in_ready, out_valid, out);
        end
        @(negedge clk);
        reset = 1'b0;
        issue(7'h18, 7'h10);
        wait_valid(lat);
        checks++;
        if (lat !== 10 || out !== 7'h0C || overflow !== 1'b0) begin
            fails++;
            $display("FAIL midreset_after got lat=%0d out=%h ovf=%b want 10 0c 0",
                     lat, out, overflow);
        end
        ack();
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        test_reset();
        test_basic();
        test_large();
        test_trunc();
        test_div_zero();
        test_backpressure();
        test_busy_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
